// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, colours, cursor FSM states and moveData layout.
// Used by the cursor controller and the board painter.
package chess_pkg;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        KING   = 3'd1,
        QUEEN  = 3'd2,
        ROOK   = 3'd3,
        BISHOP = 3'd4,
        KNIGHT = 3'd5,
        PAWN   = 3'd6
    } piece_t;

    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    typedef enum logic [1:0] {
        BROWSE   = 2'd0,
        SELECTED = 2'd1,
        PENDING  = 2'd2
    } cursor_state_t;

    localparam int MD_W        = 14;
    localparam int MD_CUR_LSB  = 0;
    localparam int MD_SRC_LSB  = 6;
    localparam int MD_SEL_BIT  = 12;
    localparam int MD_PEND_BIT = 13;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, one-cycle press pulse.
// Latency DEBOUNCE_CYCLES+2 from a stable raw press; releases never pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync_q;
    logic [1:0]    fill_q;
    logic          primed_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;

    // Once the synchroniser has filled after reset, its output becomes the
    // baseline level directly, so a button held through reset never pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b00;
            fill_q   <= 2'd0;
            primed_q <= 1'b0;
            level_q  <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            press_q <= 1'b0;
            if (!primed_q) begin
                if (fill_q == 2'd2) begin
                    level_q  <= sync_q[1];
                    primed_q <= 1'b1;
                end else begin
                    fill_q <= fill_q + 2'd1;
                end
            end else if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
                press_q <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/move_cursor_ctrl.sv
// Board cursor and move-selection FSM driving the painter's moveData bus; one-cycle update after a press.
// Macro CURSOR_WRAP_EN makes the cursor wrap at the board edges instead of saturating.
module move_cursor_ctrl
    import chess_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btnUp,
    input  logic             btnDown,
    input  logic             btnLeft,
    input  logic             btnRight,
    input  logic             btnCenter,
    input  logic [255:0]     board,
    input  logic             turn,
    input  logic             move_ack,
    input  logic             move_nak,
    output logic [MD_W-1:0]  moveData
);

    logic [4:0] raw;    // {center, up, down, left, right}
    logic [4:0] press;

    assign raw = {btnCenter, btnUp, btnDown, btnLeft, btnRight};

    for (genvar g = 0; g < 5; g++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .rst_n   (reset),
            .btn_i   (raw[g]),
            .press_o (press[g])
        );
    end

    function automatic logic [2:0] coord_step(input logic [2:0] c, input logic inc);
`ifdef CURSOR_WRAP_EN
        return inc ? c + 3'd1 : c - 3'd1;
`else
        if (inc) return (c == 3'd7) ? c : c + 3'd1;
        else     return (c == 3'd0) ? c : c - 3'd1;
`endif
    endfunction

    cursor_state_t state_q, state_d;
    logic [5:0]    cur_q, cur_d;
    logic [5:0]    src_q, src_d;
    logic [3:0]    piece;

    assign piece = board[{cur_q, 2'b00} +: 4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BROWSE;
            cur_q   <= 6'd0;
            src_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        src_d   = src_q;
        case (state_q)
            BROWSE, SELECTED: begin
                if (press[4]) begin
                    if (state_q == BROWSE) begin
                        if (piece[2:0] != EMPTY && piece[3] == turn) begin
                            state_d = SELECTED;
                            src_d   = cur_q;
                        end
                    end else if (cur_q == src_q) begin
                        state_d = BROWSE;
                    end else begin
                        state_d = PENDING;
                    end
                end else if (press[3]) begin
                    cur_d[2:0] = coord_step(cur_q[2:0], 1'b0);
                end else if (press[2]) begin
                    cur_d[2:0] = coord_step(cur_q[2:0], 1'b1);
                end else if (press[1]) begin
                    cur_d[5:3] = coord_step(cur_q[5:3], 1'b0);
                end else if (press[0]) begin
                    cur_d[5:3] = coord_step(cur_q[5:3], 1'b1);
                end
            end
            PENDING: begin
                if (move_ack)      state_d = BROWSE;
                else if (move_nak) state_d = SELECTED;
            end
            default: state_d = BROWSE;
        endcase
    end

    // Selected/pending flags are pure decodes of the registered state.
    assign moveData = {state_q == PENDING, state_q != BROWSE, src_q, cur_q};

endmodule

// File: doc/move_cursor_ctrl.md
MOVE_CURSOR_CTRL -- requirements
Module: move_cursor_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of stable clk cycles required before a button change is accepted (10 ms at 100 MHz).
REQ-002 clk  input  1  100 MHz system clock, the single clock of the block.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 btnUp, btnDown, btnLeft, btnRight, btnCenter  input  1 each  raw asynchronous push-buttons, high when pressed.
REQ-005 board  input  256  board state, square s = {let,num} at board[s*4 +: 4]; bit 3 is colour (0 white, 1 black), bits 2:0 are the type (000 empty).
REQ-006 turn  input  1  side to move (0 white, 1 black).
REQ-007 move_ack  input  1  one-cycle pulse from game logic: pending move accepted.
REQ-008 move_nak  input  1  one-cycle pulse from game logic: pending move rejected.
REQ-009 moveData  output  14  [5:0] cursor {let,num}, [11:6] source square, [12] selected, [13] move pending; this bus drives the painter's moveData directly.

Function
REQ-010 Each button SHALL be synchronised by 2 flops, debounced, and converted to a one-cycle press pulse on a stable 0->1 transition.
REQ-011 Press-pulse latency SHALL be DEBOUNCE_CYCLES+2 clk cycles from a stable raw press; release SHALL NOT produce a pulse.
REQ-012 Only one press SHALL be acted on per cycle; priority is center > up > down > left > right, and lower-priority pulses in the same cycle are discarded.
REQ-013 Direction effects: left/right decrement/increment let; up/down decrement/increment num.
REQ-014 At the edges (let or num at 0 or 7), a move beyond the edge follows REQ-028/029.
REQ-015 The FSM SHALL have states BROWSE, SELECTED and PENDING, encoded in 2 bits.
REQ-016 In BROWSE, center SHALL enter SELECTED and latch source=cursor, selected=1 only if the piece at the cursor is non-empty and its colour equals turn; otherwise center is ignored.
REQ-017 In SELECTED, center on cursor==source SHALL return to BROWSE and clear selected (source retained).
REQ-018 In SELECTED, center on cursor!=source SHALL enter PENDING and set moveData[13]=1; the destination is the cursor value.
REQ-019 In BROWSE and SELECTED, direction presses SHALL move the cursor.
REQ-020 In PENDING, all button pulses SHALL be ignored, and cursor, source and selected SHALL be frozen.
REQ-021 In PENDING, move_ack SHALL go to BROWSE and clear moveData[13:12] on the next edge.
REQ-022 In PENDING, move_nak SHALL go to SELECTED and clear moveData[13] on the next edge.
REQ-023 If move_ack and move_nak arrive together, move_ack wins.
REQ-024 move_ack and move_nak outside PENDING SHALL be ignored.
REQ-025 A change of turn while in SELECTED SHALL NOT cancel the selection.
REQ-026 All moveData bits SHALL be registered and updated on the clk edge following the accepted pulse, a latency of 1 cycle.

Reset
REQ-027 While reset is low: state=BROWSE, moveData=14'd0, debounce counters and synchronisers cleared, no pulses emitted; this applies mid-debounce and mid-PENDING, and no pulse is emitted on reset release for a button already held.

Configuration
REQ-028 Macro CURSOR_WRAP_EN defined: let and num wrap modulo 8 (7+1 -> 0, 0-1 -> 7).
REQ-029 Macro CURSOR_WRAP_EN undefined: let and num saturate at 0 and 7, and an edge press leaves the cursor unchanged.

Structure
REQ-030 The shared package/include chess_pkg SHALL hold the piece type codes (EMPTY..PAWN), the colours WHITE/BLACK, the FSM state encodings and the moveData field offsets; the painter uses the same package.
REQ-031 There SHALL be one sub-module, btn_debounce (synchroniser + counter + edge pulse, parameter DEBOUNCE_CYCLES), instantiated 5 times.
REQ-032 The FSM and cursor logic SHALL live in move_cursor_ctrl.

Verification (DEBOUNCE_CYCLES=4 in bench)
REQ-033 Reset, then btnRight held 10 cycles -> after 6 cycles moveData[5:0]=6'o10, with exactly one increment.
REQ-034 Cursor at let=7; btnRight pressed -> moveData[5:3]=0 with CURSOR_WRAP_EN, 7 without.
REQ-035 turn=0, white pawn at square 6'd1; cursor=1, center pressed -> moveData[12]=1 and [11:6]=1; with board[7:4]=4'b1110 (black) -> no change.
REQ-036 From SELECTED at source=1: cursor to 2, center -> moveData[13]=1; further buttons ignored; move_nak -> [13]=0 and [12]=1; center again, then move_ack -> moveData[13:12]=0 and state BROWSE.
REQ-037 btnCenter and btnLeft pulses in the same cycle -> only the center action occurs; reset asserted during PENDING -> moveData=0 immediately (asynchronous).
